// File: rtl/enable_gen.sv
// Start/stop enable generator: synchronised, debounced push-button
// toggling a STOP/RUN FSM that gates a DIV-cycle enable prescaler.
module enable_gen #(
    parameter int DIV = 10,
    parameter int DEB = 4
) (
    input  logic NEclk,
    input  logic Nreset,
    input  logic Btn,
    input  logic Clr,
    output logic Enable,
    output logic Running
);

    localparam int PW = $clog2(DIV);
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;

    localparam logic [0:0] STOP = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DMAX = DW'(DEB - 1);

    logic          s1;
    logic          s2;
    logic          db;
    logic [DW-1:0] dcnt;
    logic          settle;
    logic          press;

    logic [0:0]    state;
    logic [0:0]    state_nx;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nx;
    logic          en_nx;
    logic          do_clr;
    logic          do_tog;
    logic          do_step;

    always_ff @(negedge NEclk or negedge Nreset) begin
        if (!Nreset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= Btn;
            s2 <= s1;
        end
    end

    // db follows s2 only after DEB consecutive disagreeing edges
    assign settle = (s2 != db) && (dcnt == DMAX);
    assign press  = settle && s2;

    always_ff @(negedge NEclk or negedge Nreset) begin
        if (!Nreset) begin
            db   <= 1'b0;
            dcnt <= '0;
        end else if (s2 == db) begin
            dcnt <= '0;
        end else if (dcnt == DMAX) begin
            db   <= s2;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // clear beats a press; a toggle edge never advances the prescaler
    assign do_clr  = Clr;
    assign do_tog  = press && !Clr;
    assign do_step = (state == RUN) && !Clr && !press;

    always_comb begin
        state_nx = state;
        pre_nx   = pre;
        en_nx    = 1'b0;
        unique case (1'b1)
            do_clr: begin
                state_nx = STOP;
                pre_nx   = '0;
            end
            do_tog: begin
                state_nx = ~state;
            end
            do_step: begin
                if (pre == PMAX) begin
                    pre_nx = '0;
                    en_nx  = 1'b1;
                end else begin
                    pre_nx = pre + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(negedge NEclk or negedge Nreset) begin
        if (!Nreset) begin
            state   <= STOP;
            pre     <= '0;
            Enable  <= 1'b0;
            Running <= 1'b0;
        end else begin
            state   <= state_nx;
            pre     <= pre_nx;
            Enable  <= en_nx;
            Running <= (state_nx == RUN);
        end
    end

endmodule

// File: tb/tb_enable_gen.sv
// Randomised and directed bench for enable_gen (DIV=4, DEB=3)
// against an edge-level behavioural model.
module tb_enable_gen;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic NEclk;
    logic Nreset;
    logic Btn;
    logic Clr;
    logic Enable;
    logic Running;

    int checks;
    int errors;

    bit m_s1, m_s2, m_db, m_run, m_en;
    int m_cnt, m_phase;

    enable_gen #(.DIV(DIV), .DEB(DEB)) dut (
        .NEclk  (NEclk),
        .Nreset (Nreset),
        .Btn    (Btn),
        .Clr    (Clr),
        .Enable (Enable),
        .Running(Running)
    );

    initial begin
        NEclk = 1'b1;
        forever #5 NEclk = ~NEclk;
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_en = 0;
        m_cnt = 0; m_phase = 0;
    endtask

    // One falling edge of the reference: uses pre-edge values throughout
    task automatic model_edge(input bit b, input bit c);
        bit pr;
        pr = 0;
        if (m_s2 != m_db) begin
            m_cnt++;
            if (m_cnt == DEB) begin
                m_db  = m_s2;
                m_cnt = 0;
                pr    = m_db;
            end
        end else begin
            m_cnt = 0;
        end
        m_en = 0;
        if (c) begin
            m_run   = 0;
            m_phase = 0;
        end else if (pr) begin
            m_run = !m_run;
        end else if (m_run) begin
            m_phase = (m_phase + 1) % DIV;
            m_en    = (m_phase == 0);
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic tick(input logic b, input logic c);
        Btn = b;
        Clr = c;
        @(negedge NEclk);
        model_edge(b, c);
        #1;
        chk("en", Enable, m_en);
        chk("run", Running, m_run);
    endtask

    task automatic do_reset(input logic b);
        Btn = b;
        Clr = 1'b0;
        Nreset = 1'b0;
        mreset();
        #1;
        chk("rst_en", Enable, 1'b0);
        chk("rst_run", Running, 1'b0);
        @(posedge NEclk);
        #2;
        Nreset = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
    endtask

    initial begin
        bit found;
        bit rb;
        checks = 0;
        errors = 0;
        Btn = 0;
        Clr = 0;
        Nreset = 1;
        #2;
        do_reset(1'b0);

        // start-up press: toggle on edge 5, pulses after 9, 13, 17
        for (int i = 1; i <= 17; i++) begin
            tick(1'b1, 1'b0);
            chk("r033_run", Running, i >= 5);
            chk("r033_en", Enable, i == 9 || i == 13 || i == 17);
        end
        idle(6);

        // stop press landing on the wrap edge
        found = 0;
        for (int n = 0; n < 8 && !found; n++) begin
            if (m_phase == DIV - 1) found = 1;
            else tick(1'b0, 1'b0);
        end
        chk("r035_align", found, 1'b1);
        for (int i = 1; i <= 5; i++) tick(1'b1, 1'b0);
        chk("r035_en", Enable, 1'b0);
        chk("r035_run", Running, 1'b0);
        idle(6);

        // resume from held DIV-1: enable one edge after toggle
        for (int i = 1; i <= 5; i++) tick(1'b1, 1'b0);
        chk("r036_run", Running, 1'b1);
        tick(1'b1, 1'b0);
        chk("r036_en", Enable, 1'b1);
        idle(6);

        // clear while prescaler is 2
        found = 0;
        for (int n = 0; n < 8 && !found; n++) begin
            if (m_phase == 2) found = 1;
            else tick(1'b0, 1'b0);
        end
        chk("r037_align", found, 1'b1);
        tick(1'b0, 1'b1);
        chk("r037_run", Running, 1'b0);
        chk("r037_en", Enable, 1'b0);
        idle(4);
        for (int i = 1; i <= 5; i++) tick(1'b1, 1'b0);
        for (int k = 1; k <= DIV; k++) begin
            tick(1'b1, 1'b0);
            chk("r037_resume", Enable, k == DIV);
        end
        tick(1'b0, 1'b1);
        idle(6);

        // clear coinciding with a press
        for (int i = 1; i <= 4; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("r038_run", Running, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            chk("r038_hold", Running, 1'b0);
        end
        idle(6);

        // short glitch is rejected
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0);
            chk("r034_run", Running, 1'b0);
            chk("r034_en", Enable, 1'b0);
        end

        // async reset during an enable pulse
        for (int i = 1; i <= 5; i++) tick(1'b1, 1'b0);
        found = 0;
        for (int n = 0; n < 12 && !found; n++) begin
            tick(1'b0, 1'b0);
            if (Enable) found = 1;
        end
        chk("r039_pulse", found, 1'b1);
        #2;
        Nreset = 1'b0;
        mreset();
        #1;
        chk("r039_en", Enable, 1'b0);
        chk("r039_run", Running, 1'b0);
        @(posedge NEclk);
        #2;
        Nreset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            chk("r040_run", Running, 1'b0);
            chk("r040_en", Enable, 1'b0);
        end

        // button held through reset release
        do_reset(1'b1);
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b0);
            chk("r032_run", Running, i >= 5);
        end

        // random traffic
        rb = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) rb = !rb;
            tick(rb, $urandom_range(0, 40) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
